// File: rtl/enc_period_pkg.sv
// Shared types and constants for the encoder period snapshot scheduler:
// FSM state encoding, default channel count and period-word field layout.
package enc_period_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } snap_state_e;

    localparam int DEF_NUM_CH  = 4;

    // Period word layout: status flags on top, free-running count at the bottom
    localparam int PW_RUN_BIT    = 31;
    localparam int PW_DIR_BIT    = 30;
    localparam int PW_DIRCHG_BIT = 29;
    localparam int PW_CNT_MSB    = 21;
    localparam int PW_CNT_LSB    = 0;
    localparam int PW_CNT_W      = PW_CNT_MSB - PW_CNT_LSB + 1;

    function automatic logic [PW_CNT_W-1:0] pw_count(input logic [31:0] word);
        return word[PW_CNT_MSB:PW_CNT_LSB];
    endfunction

endpackage

// File: rtl/enc_period_sched_if.sv
// Snapshot bus between the scheduler, the external period mux, the shadow
// buffer and the stale-flag consumer. The scheduler uses the slave modport.
interface enc_period_sched_if
    import enc_period_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int CH_W    = 2,
    parameter int STALE_W = 8
);
    logic                snap_req;
    logic                snap_busy;
    logic [CH_W-1:0]     ch_sel;
    logic [31:0]         period_in;
    logic                buf_we;
    logic [CH_W-1:0]     buf_waddr;
    logic [31:0]         buf_wdata;
    logic                snap_done;
    logic [STALE_W-1:0]  stale_limit;
    logic [NUM_CH-1:0]   stale;

    modport master (
        output snap_req, period_in, stale_limit,
        input  snap_busy, ch_sel, buf_we, buf_waddr, buf_wdata, snap_done, stale
    );

    modport slave (
        input  snap_req, period_in, stale_limit,
        output snap_busy, ch_sel, buf_we, buf_waddr, buf_wdata, snap_done, stale
    );
endinterface

// File: rtl/enc_stale_cnt.sv
// One channel of stale detection: remembers the last captured count field and
// counts consecutive snapshots in which it did not move.
module enc_stale_cnt
    import enc_period_pkg::*;
#(
    parameter int STALE_W = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                we_i,
    input  logic [PW_CNT_W-1:0] value_i,
    input  logic [STALE_W-1:0]  limit_i,
    output logic                stale_o
);
    localparam logic [STALE_W-1:0] CNT_MAX = {STALE_W{1'b1}};

    logic [PW_CNT_W-1:0] prev_q, prev_d;
    logic [STALE_W-1:0]  cnt_q, cnt_d;
    logic                stale_q, stale_d;

    // Next-state: saturating repeat counter, flag evaluated on the new count
    always_comb begin
        prev_d = prev_q;
        cnt_d  = cnt_q;
        if (we_i) begin
            prev_d = value_i;
            if (value_i == prev_q) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + STALE_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end else begin
                cnt_d = '0;
            end
        end else begin
            cnt_d = cnt_q;
        end
        stale_d = (limit_i != '0) && (cnt_d >= limit_i);
    end

    // State registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prev_q  <= '0;
            cnt_q   <= '0;
            stale_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            stale_q <= stale_d;
        end
    end

    assign stale_o = stale_q;

endmodule

// File: rtl/enc_period_sched.sv
// Snapshot scheduler: walks every channel through the external period mux and
// copies each word into the shadow buffer. Stale detection: ENC_STALE_CHECK_EN.
module enc_period_sched
    import enc_period_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int CH_W    = 2,
    parameter int STALE_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    enc_period_sched_if.slave  bus
);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    snap_state_e        state_q;
    logic               pending_q;
    logic [CH_W-1:0]    ch_sel_q;
    logic               buf_we_q;
    logic [CH_W-1:0]    buf_waddr_q;
    logic [31:0]        buf_wdata_q;
    logic               snap_done_q;
    logic               snap_busy_q;

    // Sequencer; outputs are registered from the state being entered.
    // A request seen in DONE (or already pending) chains straight into SETTLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            pending_q   <= 1'b0;
            ch_sel_q    <= '0;
            buf_we_q    <= 1'b0;
            buf_waddr_q <= '0;
            buf_wdata_q <= 32'h0000_0000;
            snap_done_q <= 1'b0;
            snap_busy_q <= 1'b0;
        end else begin
            buf_we_q    <= 1'b0;
            snap_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.snap_req || pending_q) begin
                        state_q     <= ST_SETTLE;
                        ch_sel_q    <= '0;
                        pending_q   <= 1'b0;
                        snap_busy_q <= 1'b1;
                    end else begin
                        snap_busy_q <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    state_q     <= ST_WRITE;
                    buf_we_q    <= 1'b1;
                    buf_waddr_q <= ch_sel_q;
                    buf_wdata_q <= bus.period_in;
                    pending_q   <= pending_q | bus.snap_req;
                    snap_busy_q <= 1'b1;
                end
                ST_WRITE: begin
                    if (ch_sel_q == LAST_CH) begin
                        state_q     <= ST_DONE;
                        snap_done_q <= 1'b1;
                    end else begin
                        state_q  <= ST_SETTLE;
                        ch_sel_q <= ch_sel_q + CH_W'(1);
                    end
                    pending_q   <= pending_q | bus.snap_req;
                    snap_busy_q <= 1'b1;
                end
                ST_DONE: begin
                    if (bus.snap_req || pending_q) begin
                        state_q     <= ST_SETTLE;
                        ch_sel_q    <= '0;
                        snap_busy_q <= 1'b1;
                    end else begin
                        state_q     <= ST_IDLE;
                        snap_busy_q <= 1'b0;
                    end
                    pending_q <= 1'b0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    pending_q   <= 1'b0;
                    snap_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.snap_busy = snap_busy_q;
    assign bus.ch_sel    = ch_sel_q;
    assign bus.buf_we    = buf_we_q;
    assign bus.buf_waddr = buf_waddr_q;
    assign bus.buf_wdata = buf_wdata_q;
    assign bus.snap_done = snap_done_q;

`ifdef ENC_STALE_CHECK_EN
    logic [NUM_CH-1:0] stale_s;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_stale
        enc_stale_cnt #(
            .STALE_W (STALE_W)
        ) u_stale_cnt (
            .clk_i   (clk),
            .rst_ni  (reset),
            .we_i    (buf_we_q && (buf_waddr_q == CH_W'(g))),
            .value_i (pw_count(buf_wdata_q)),
            .limit_i (bus.stale_limit),
            .stale_o (stale_s[g])
        );
    end

    assign bus.stale = stale_s;
`else
    logic unused_limit_s;
    assign unused_limit_s = ^bus.stale_limit;
    assign bus.stale      = '0;
`endif

endmodule

// File: tb/tb_enc_period_sched.sv
// Self-checking bench for enc_period_sched: directed and random request
// patterns against a snapshot-schedule model, mid-sequence reset, stale flags.
module tb_enc_period_sched;
    import enc_period_pkg::*;

    localparam int NUM_CH   = 4;
    localparam int CH_W     = 2;
    localparam int STALE_W  = 8;
    localparam int SNAP_LEN = 2 * NUM_CH + 1;
    localparam int NCYC     = 72;

    logic        clk = 1'b0;
    logic        reset;
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] vals [NUM_CH];

    enc_period_sched_if #(.NUM_CH(NUM_CH), .CH_W(CH_W), .STALE_W(STALE_W)) bus ();

    enc_period_sched #(.NUM_CH(NUM_CH), .CH_W(CH_W), .STALE_W(STALE_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // External period mux
    always_comb bus.period_in = vals[bus.ch_sel];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected timeline from the request pattern: a snapshot sampled at
    // cycle s is busy s+1..s+2N+1, writes ch c at s+2+2c, done at s+2N+1.
    task automatic run_sched(input string name, input logic [NCYC-1:0] mask);
        logic        e_busy [NCYC+1];
        logic        e_we   [NCYC+1];
        logic        e_done [NCYC+1];
        int          e_addr [NCYC+1];
        logic [31:0] e_data [NCYC+1];
        int          last_end = -1;
        bit          pend = 1'b0;
        for (int t = 0; t <= NCYC; t++) begin
            e_busy[t] = 1'b0; e_we[t] = 1'b0; e_done[t] = 1'b0;
            e_addr[t] = 0;    e_data[t] = 32'h0;
        end
        for (int t = 0; t < NCYC; t++) begin
            bit active  = (t <= last_end);
            bit is_done = (t == last_end);
            if ((!active || is_done) && (mask[t] || pend)) begin
                for (int k = 1; k <= SNAP_LEN; k++)
                    if (t + k <= NCYC) e_busy[t+k] = 1'b1;
                for (int c = 0; c < NUM_CH; c++)
                    if (t + 2 + 2*c <= NCYC) begin
                        e_we[t+2+2*c]   = 1'b1;
                        e_addr[t+2+2*c] = c;
                        e_data[t+2+2*c] = vals[c];
                    end
                if (t + SNAP_LEN <= NCYC) e_done[t+SNAP_LEN] = 1'b1;
                last_end = t + SNAP_LEN;
                pend = 1'b0;
            end else if (active && mask[t]) begin
                pend = 1'b1;
            end
        end
        for (int t = 0; t < NCYC; t++) begin
            bus.snap_req = mask[t];
            step();
            chk($sformatf("%s busy@%0d", name, t+1), bus.snap_busy, e_busy[t+1]);
            chk($sformatf("%s we@%0d",   name, t+1), bus.buf_we,    e_we[t+1]);
            chk($sformatf("%s done@%0d", name, t+1), bus.snap_done, e_done[t+1]);
            if (e_we[t+1]) begin
                chk($sformatf("%s waddr@%0d", name, t+1), bus.buf_waddr, e_addr[t+1]);
                chk($sformatf("%s wdata@%0d", name, t+1), bus.buf_wdata, e_data[t+1]);
            end
        end
        bus.snap_req = 1'b0;
    endtask

    task automatic do_snap();
        int n = 0;
        bus.snap_req = 1'b1;
        step();
        bus.snap_req = 1'b0;
        while (!bus.snap_done && n < 40) begin
            step();
            n++;
        end
        chk("snap_done_within_bound", (n < 40), 1'b1);
        step();
    endtask

    initial begin
        logic [NCYC-1:0] mask;
        int              cnt_m  [NUM_CH];
        logic [21:0]     prev_m [NUM_CH];
        logic [NUM_CH-1:0] exp_stale;

        reset           = 1'b0;
        bus.snap_req    = 1'b0;
        bus.stale_limit = 8'd0;
        for (int c = 0; c < NUM_CH; c++) vals[c] = 32'h100 + 32'(c);
        repeat (3) step();
        chk("rst busy",  bus.snap_busy, 1'b0);
        chk("rst we",    bus.buf_we,    1'b0);
        chk("rst done",  bus.snap_done, 1'b0);
        chk("rst chsel", bus.ch_sel,    2'd0);
        chk("rst waddr", bus.buf_waddr, 2'd0);
        chk("rst wdata", bus.buf_wdata, 32'h0);
        chk("rst stale", bus.stale,     4'h0);
        reset = 1'b1;
        step();

        // Single snapshot with data 0x100+ch
        mask = '0; mask[0] = 1'b1;
        run_sched("single", mask);

        // Requests at 0, 3, 5 coalesce into one follow-on snapshot
        mask = '0; mask[0] = 1'b1; mask[3] = 1'b1; mask[5] = 1'b1;
        run_sched("coalesce", mask);

        // Request in the DONE cycle
        mask = '0; mask[0] = 1'b1; mask[SNAP_LEN] = 1'b1;
        run_sched("done_req", mask);

        // Random request patterns and period words including status bits
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < NUM_CH; c++) vals[c] = $urandom;
            mask = '0;
            mask[23:0] = 24'($urandom & $urandom);
            run_sched($sformatf("rand%0d", r), mask);
        end

        // Reset asserted at cycle 4 of a snapshot
        bus.snap_req = 1'b1;
        step();
        bus.snap_req = 1'b0;
        repeat (3) step();
        chk("midrst busy_before", bus.snap_busy, 1'b1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        for (int t = 0; t < 12; t++) begin
            chk($sformatf("midrst we@%0d", t),    bus.buf_we,    1'b0);
            chk($sformatf("midrst done@%0d", t),  bus.snap_done, 1'b0);
            chk($sformatf("midrst chsel@%0d", t), bus.ch_sel,    2'd0);
            step();
        end

        // Stale detection: ch2 count field frozen, others moving
        bus.stale_limit = 8'd3;
        for (int c = 0; c < NUM_CH; c++) begin
            cnt_m[c]  = 0;
            prev_m[c] = 22'h0;
        end
        for (int k = 0; k < 7; k++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (c == 2)
                    vals[c] = {3'($urandom), 7'($urandom), (k < 6) ? 22'h00ABCD : 22'h012345};
                else
                    vals[c] = {3'($urandom), 7'($urandom), 22'(k * 37 + c + 1)};
            end
            do_snap();
            for (int c = 0; c < NUM_CH; c++) begin
                if (vals[c][21:0] == prev_m[c])
                    cnt_m[c] = (cnt_m[c] < 255) ? cnt_m[c] + 1 : 255;
                else
                    cnt_m[c] = 0;
                prev_m[c] = vals[c][21:0];
            end
            for (int c = 0; c < NUM_CH; c++) begin
`ifdef ENC_STALE_CHECK_EN
                exp_stale[c] = (bus.stale_limit != 8'd0) && (cnt_m[c] >= int'(bus.stale_limit));
`else
                exp_stale[c] = 1'b0;
`endif
            end
            chk($sformatf("stale snap%0d", k+1), bus.stale, exp_stale);
            if (k == 5) begin
                bus.stale_limit = 8'd0;
                step();
                chk("stale limit0", bus.stale, 4'h0);
                bus.stale_limit = 8'd3;
                step();
                chk("stale limit3", bus.stale, exp_stale);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
